// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if
//   Bundles the request/response and SPI-master signals of spi_arbiter.
//   slave  modport: the arbiter's view (inputs: req, tx0, tx1, spi_rx;
//                   outputs: done, rx_data, busy, spi_en, spi_tx).
//   master modport: the opposite direction, for the requesters/SPI side.
interface spi_arbiter_if;
    logic [1:0] req;
    logic [7:0] tx0;
    logic [7:0] tx1;
    logic [1:0] done;
    logic [7:0] rx_data;
    logic       busy;
    logic       spi_en;
    logic [7:0] spi_tx;
    logic [7:0] spi_rx;

    modport slave (
        input  req, tx0, tx1, spi_rx,
        output done, rx_data, busy, spi_en, spi_tx
    );

    modport master (
        output req, tx0, tx1, spi_rx,
        input  done, rx_data, busy, spi_en, spi_tx
    );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter
//   Two-requester round-robin arbiter in front of an SPI master. A grant
//   latches the winner's byte, waits SETUP_CYC cycles, holds spi_en high for
//   FRAME_CYC cycles, captures spi_rx in a one-cycle CAPTURE state, pulses
//   done for the winner on the first GAP cycle and idles GAP_CYC cycles.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - spi_arbiter_if.slave: req, tx0, tx1, spi_rx in;
//          done, rx_data, busy, spi_en, spi_tx out
module spi_arbiter #(
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned FRAME_CYC = 32,
    parameter int unsigned GAP_CYC   = 8
) (
    input  logic          clk,
    input  logic          rst,
    spi_arbiter_if.slave  bus
);

    localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC);
    localparam logic [15:0] FRAME_LD = 16'(FRAME_CYC);
    localparam logic [15:0] GAP_LD   = 16'(GAP_CYC);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        XFER    = 3'd2,
        CAPTURE = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        ptr_q,   ptr_d;
    logic        g_q,     g_d;
    logic [7:0]  tx_q,    tx_d;
    logic [7:0]  rx_q,    rx_d;
    logic [1:0]  done_q,  done_d;
    logic        en_q,    en_d;
    logic        win;

    // Tie goes to the requester that was not granted last; a lone request
    // always wins.
    assign win = bus.req[1] & (~bus.req[0] | ~ptr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b1;
            g_q     <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            done_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            done_q  <= done_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        done_d  = 2'b00;

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    g_d     = win;
                    ptr_d   = win;
                    tx_d    = win ? bus.tx1 : bus.tx0;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 16'd1) begin
                    cnt_d   = FRAME_LD;
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            XFER: begin
                if (cnt_q == 16'd1) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            CAPTURE: begin
                rx_d    = bus.spi_rx;
                done_d  = g_q ? 2'b10 : 2'b01;
                cnt_d   = GAP_LD;
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q == 16'd1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // spi_en is a register that is high exactly while the state is XFER.
        en_d = (state_d == XFER);
    end

    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.spi_en  = en_q;
    assign bus.spi_tx  = tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    spi_arbiter_if bus();

    spi_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req    = 2'b00;
        bus.tx0    = 8'h00;
        bus.tx1    = 8'h00;
        bus.spi_rx = 8'h00;
        do_reset();
        checks += 5;
        if (bus.spi_en !== 1'b0) begin failures++; $display("FAIL reset_spi_en got=%b exp=0", bus.spi_en); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", bus.done); end
        if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
        if (bus.spi_tx !== 8'h00) begin failures++; $display("FAIL reset_spi_tx got=%h exp=00", bus.spi_tx); end
        $display("reset: spi_en=%b busy=%b done=%b rx=%h tx=%h", bus.spi_en, bus.busy, bus.done, bus.rx_data, bus.spi_tx);
    endtask

    // Sample i is taken just after edge i, where edge 0 is the grant edge.
    task automatic test_single();
        logic       exp_en;
        logic [1:0] exp_done;
        logic       exp_busy;
        bus.req    = 2'b01;
        bus.tx0    = 8'h30;
        bus.tx1    = 8'h99;
        bus.spi_rx = 8'h41;
        for (int i = 0; i <= 45; i++) begin
            tick();
            if (i == 0) begin
                bus.req = 2'b00;
                checks++;
                if (bus.spi_tx !== 8'h30) begin failures++; $display("FAIL single_spi_tx got=%h exp=30", bus.spi_tx); end
            end
            exp_en   = (i >= 4) && (i <= 35);
            exp_done = (i == 37) ? 2'b01 : 2'b00;
            exp_busy = (i < 45);
            checks += 3;
            if (bus.spi_en !== exp_en) begin failures++; $display("FAIL single_spi_en cyc=%0d got=%b exp=%b", i, bus.spi_en, exp_en); end
            if (bus.done !== exp_done) begin failures++; $display("FAIL single_done cyc=%0d got=%b exp=%b", i, bus.done, exp_done); end
            if (bus.busy !== exp_busy) begin failures++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", i, bus.busy, exp_busy); end
            if (i == 37) begin
                checks++;
                if (bus.rx_data !== 8'h41) begin failures++; $display("FAIL single_rx_data got=%h exp=41", bus.rx_data); end
            end
        end
        $display("single: tx=%h rx=%h busy=%b", bus.spi_tx, bus.rx_data, bus.busy);
    endtask

    task automatic test_tie();
        logic [7:0] exp_tx;
        logic [1:0] exp_done;
        do_reset();
        bus.req = 2'b11;
        bus.tx0 = 8'h30;
        bus.tx1 = 8'h41;
        for (int k = 0; k < 4; k++) begin
            exp_tx   = (k % 2 == 0) ? 8'h30 : 8'h41;
            exp_done = (k % 2 == 0) ? 2'b01 : 2'b10;
            bus.spi_rx = 8'h50 + 8'(k);
            for (int i = 0; i <= 45; i++) begin
                tick();
                if (i == 0 || i == 44) begin
                    checks += 2;
                    if (bus.spi_tx !== exp_tx) begin failures++; $display("FAIL tie_spi_tx grant=%0d cyc=%0d got=%h exp=%h", k, i, bus.spi_tx, exp_tx); end
                    if (bus.busy !== 1'b1) begin failures++; $display("FAIL tie_busy grant=%0d cyc=%0d got=%b exp=1", k, i, bus.busy); end
                end
                if (i == 37) begin
                    checks += 2;
                    if (bus.done !== exp_done) begin failures++; $display("FAIL tie_done grant=%0d got=%b exp=%b", k, bus.done, exp_done); end
                    if (bus.rx_data !== 8'h50 + 8'(k)) begin failures++; $display("FAIL tie_rx_data grant=%0d got=%h exp=%h", k, bus.rx_data, 8'h50 + 8'(k)); end
                end
                if (i == 45) begin
                    checks++;
                    if (bus.busy !== 1'b0) begin failures++; $display("FAIL tie_idle grant=%0d got=%b exp=0", k, bus.busy); end
                end
            end
            $display("tie: grant=%0d tx=%h done_seen rx=%h", k, bus.spi_tx, bus.rx_data);
        end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        bus.req    = 2'b10;
        bus.tx0    = 8'h30;
        bus.tx1    = 8'h41;
        bus.spi_rx = 8'h77;
        // Grant requester 1 so the pointer is 1 before the abort anyway;
        // reset must still leave requester 0 winning the next tie.
        for (int i = 0; i <= 13; i++) begin
            tick();
            if (i == 0) bus.req = 2'b00;
        end
        checks++;
        if (bus.spi_en !== 1'b1) begin failures++; $display("FAIL abort_pre_en got=%b exp=1", bus.spi_en); end
        rst = 1'b1;
        tick();
        checks += 3;
        if (bus.spi_en !== 1'b0) begin failures++; $display("FAIL abort_spi_en got=%b exp=0", bus.spi_en); end
        if (bus.done !== 2'b00) begin failures++; $display("FAIL abort_done got=%b exp=00", bus.done); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        rst = 1'b0;
        bus.req = 2'b11;
        for (int i = 0; i <= 45; i++) begin
            tick();
            if (i == 0) begin
                bus.req = 2'b00;
                checks++;
                if (bus.spi_tx !== 8'h30) begin failures++; $display("FAIL abort_regrant_tx got=%h exp=30", bus.spi_tx); end
            end
            if (i == 37) begin
                checks++;
                if (bus.done !== 2'b01) begin failures++; $display("FAIL abort_regrant_done got=%b exp=01", bus.done); end
            end
        end
        $display("abort: regrant tx=%h rx=%h", bus.spi_tx, bus.rx_data);
    endtask

    task automatic test_latch_drop();
        int done_cnt;
        do_reset();
        done_cnt   = 0;
        bus.req    = 2'b01;
        bus.tx0    = 8'h30;
        bus.spi_rx = 8'h5A;
        for (int i = 0; i <= 46; i++) begin
            tick();
            if (i == 10) begin
                bus.tx0 = 8'hFF;
                bus.req = 2'b00;
            end
            if (bus.done == 2'b01) done_cnt++;
            if (i == 20 || i == 44) begin
                checks++;
                if (bus.spi_tx !== 8'h30) begin failures++; $display("FAIL latch_spi_tx cyc=%0d got=%h exp=30", i, bus.spi_tx); end
            end
            if (i == 37) begin
                checks += 2;
                if (bus.done !== 2'b01) begin failures++; $display("FAIL drop_done got=%b exp=01", bus.done); end
                if (bus.rx_data !== 8'h5A) begin failures++; $display("FAIL drop_rx_data got=%h exp=5a", bus.rx_data); end
            end
        end
        checks += 3;
        if (done_cnt !== 1) begin failures++; $display("FAIL drop_done_count got=%0d exp=1", done_cnt); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b exp=0", bus.busy); end
        if (bus.rx_data !== 8'h5A) begin failures++; $display("FAIL drop_rx_hold got=%h exp=5a", bus.rx_data); end
        $display("latch_drop: tx=%h rx=%h done_pulses=%0d", bus.spi_tx, bus.rx_data, done_cnt);
    endtask

    initial begin
        bus.req    = 2'b00;
        bus.tx0    = 8'h00;
        bus.tx1    = 8'h00;
        bus.spi_rx = 8'h00;
        test_reset();
        test_single();
        test_tie();
        test_abort();
        test_latch_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
